// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial adder word driver.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_drv_state_t;

    // The bit counter runs 0..width inclusive (width operand bits plus the carry-out bit).
    function automatic int sa_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_word_driver.sv
// Word-level front end for a bit-serial adder: shifts operands out LSB-first and
// gathers the returned sum bits (plus the final carry) into a parallel result.
module serial_adder_word_driver
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_clr,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             ser_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output sa_drv_state_t    dbg_state
);

    localparam int               CNT_W    = sa_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    sa_drv_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_res;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid/data hold until that edge, and ready never depends on valid.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign ser_clr   = (r_state != SHIFT);
    assign ser_a     = (r_state == SHIFT) ? r_a[0] : 1'b0;
    assign ser_b     = (r_state == SHIFT) ? r_b[0] : 1'b0;
    assign out_sum   = r_res;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Zero fill means the last cycle sends a=b=0, so the sum bit is the carry-out.
                    r_res <= {ser_sum, r_res[WIDTH:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_word_driver.sv
// Bench for serial_adder_word_driver: an 8-bit driver paired with an arithmetic
// serial adder and a 1-bit driver paired with a logic-ops-only serial adder.
module tb_serial_adder_word_driver;
    import serial_adder_pkg::*;

    localparam int W8 = 8;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit driver signals
    logic          in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [W8-1:0] in_a8 = '0, in_b8 = '0;
    logic          ser_clr8, ser_a8, ser_b8, ser_sum8;
    logic [W8:0]   out_sum8;
    sa_drv_state_t dbg8;

    // 1-bit driver signals
    logic          in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
    logic [W1-1:0] in_a1 = '0, in_b1 = '0;
    logic          ser_clr1, ser_a1, ser_b1, ser_sum1;
    logic [W1:0]   out_sum1;
    sa_drv_state_t dbg1;

    serial_adder_word_driver #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .ser_clr(ser_clr8), .ser_a(ser_a8),
        .ser_b(ser_b8), .ser_sum(ser_sum8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_sum(out_sum8), .dbg_state(dbg8)
    );

    serial_adder_word_driver #(.WIDTH(W1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .ser_clr(ser_clr1), .ser_a(ser_a1),
        .ser_b(ser_b1), .ser_sum(ser_sum1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sum(out_sum1), .dbg_state(dbg1)
    );

    // Peer 1: serial adder built with arithmetic; carry cleared synchronously by ser_clr.
    logic       carry8;
    logic [1:0] add8;
    assign add8     = {1'b0, ser_a8} + {1'b0, ser_b8} + {1'b0, carry8};
    assign ser_sum8 = add8[0];
    always @(posedge clk) carry8 <= ser_clr8 ? 1'b0 : add8[1];

    // Peer 2: serial adder built from logic operations only.
    logic carry1;
    assign ser_sum1 = ser_a1 ^ ser_b1 ^ carry1;
    always @(posedge clk) carry1 <= ser_clr1 ? 1'b0 : ((ser_a1 & ser_b1) | (carry1 & (ser_a1 ^ ser_b1)));

    logic [W8:0] exp8_q[$];
    logic [W1:0] exp1_q[$];
    int   acc_cyc = 0, last_acc = 0;
    logic have_last = 1'b0, prev_ov = 1'b0, b2b = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!in_ready8 && n < 40) begin
            tick();
            n++;
        end
        check("in_ready8_wait", 16'(in_ready8), 16'd1);
    endtask

    task automatic wait_valid8();
        int n = 0;
        while (!out_valid8 && n < 40) begin
            tick();
            n++;
        end
        check("out_valid8_wait", 16'(out_valid8), 16'd1);
    endtask

    task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b);
        in_a8 = a;
        in_b8 = b;
        in_valid8 = 1'b1;
        wait_ready8();
        tick();
        in_valid8 = 1'b0;
        wait_valid8();
        tick();
    endtask

    task automatic run1(input logic [W1-1:0] a, input logic [W1-1:0] b);
        int n = 0;
        in_a1 = a;
        in_b1 = b;
        in_valid1 = 1'b1;
        check("w1_in_ready", 16'(in_ready1), 16'd1);
        tick();
        in_valid1 = 1'b0;
        while (dbg1 == SHIFT && n < 10) begin
            tick();
            n++;
        end
        check("w1_shift_cycles", 16'(n), 16'd2);
        check("w1_out_valid", 16'(out_valid1), 16'd1);
        tick();
    endtask

    // Scoreboard for the 8-bit driver: expected sums pushed at accept, popped at result handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp8_q.delete();
            prev_ov = 1'b0;
            have_last = 1'b0;
        end else begin
            if (in_valid8 && in_ready8) begin
                exp8_q.push_back({1'b0, in_a8} + {1'b0, in_b8});
                if (b2b && have_last) check("b2b_spacing", 16'(cyc - last_acc), 16'(W8 + 3));
                last_acc = cyc;
                have_last = 1'b1;
                acc_cyc = cyc;
            end
            if (out_valid8 && !prev_ov) check("latency", 16'(cyc - acc_cyc - 1), 16'(W8 + 1));
            if (out_valid8 && out_ready8) begin
                if (exp8_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL w8_sum: observed=%0h expected=<none queued>", out_sum8);
                end else begin
                    check("w8_sum", 16'(out_sum8), 16'(exp8_q.pop_front()));
                end
            end
            prev_ov = out_valid8;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp1_q.delete();
        end else begin
            if (in_valid1 && in_ready1) exp1_q.push_back({1'b0, in_a1} + {1'b0, in_b1});
            if (out_valid1 && out_ready1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL w1_sum: observed=%0h expected=<none queued>", out_sum1);
                end else begin
                    check("w1_sum", 16'(out_sum1), 16'(exp1_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [W8:0] a_bits;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 16'(in_ready8), 16'd0);
        check("rst_out_valid", 16'(out_valid8), 16'd0);
        check("rst_ser_clr", 16'(ser_clr8), 16'd1);
        check("rst_out_sum", 16'(out_sum8), 16'd0);
        check("rst_state", 16'(dbg8), 16'(IDLE));
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 16'(in_ready8), 16'd1);

        // 0x5A + 0x33 with the serial bit stream checked on ser_a
        a_bits = {1'b0, 8'h5A};
        in_a8 = 8'h5A;
        in_b8 = 8'h33;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check("first_shift_ser_clr", 16'(ser_clr8), 16'd0);
        for (int i = 0; i <= W8; i++) begin
            check("ser_a_bit", 16'(ser_a8), 16'(a_bits[i]));
            tick();
        end
        check("done_out_valid", 16'(out_valid8), 16'd1);
        check("done_out_sum", 16'(out_sum8), 16'h08D);
        tick();

        // Carry ripple through every bit
        run8(8'hFF, 8'h01);
        run8(8'hFF, 8'hFF);

        // Backpressure with a pending input pair
        out_ready8 = 1'b0;
        in_a8 = 8'h5A;
        in_b8 = 8'h33;
        in_valid8 = 1'b1;
        wait_ready8();
        tick();
        in_a8 = 8'h01;
        in_b8 = 8'h01;
        wait_valid8();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_sum", 16'(out_sum8), 16'h08D);
            check("bp_in_ready", 16'(in_ready8), 16'd0);
            check("bp_out_valid", 16'(out_valid8), 16'd1);
            tick();
        end
        out_ready8 = 1'b1;
        tick();
        check("bp_accept_after", 16'(in_ready8), 16'd1);
        tick();
        in_valid8 = 1'b0;
        wait_valid8();
        check("bp_second_sum", 16'(out_sum8), 16'h002);
        tick();

        // Reset in the middle of a shift
        in_a8 = 8'hFF;
        in_b8 = 8'hFF;
        in_valid8 = 1'b1;
        wait_ready8();
        tick();
        in_valid8 = 1'b0;
        repeat (4) tick();
        check("mid_state", 16'(dbg8), 16'(SHIFT));
        rst = 1'b1;
        #1;
        check("abort_state", 16'(dbg8), 16'(IDLE));
        check("abort_out_valid", 16'(out_valid8), 16'd0);
        check("abort_ser_clr", 16'(ser_clr8), 16'd1);
        tick();
        rst = 1'b0;
        tick();
        run8(8'h01, 8'h01);
        check("post_abort_sum", 16'(out_sum8), 16'h002);

        // Back-to-back with in_valid held high
        b2b = 1'b1;
        in_valid8 = 1'b1;
        in_a8 = 8'h00;
        in_b8 = 8'h00;
        wait_ready8();
        tick();
        in_a8 = 8'h80;
        in_b8 = 8'h80;
        wait_ready8();
        tick();
        in_a8 = 8'h7F;
        in_b8 = 8'h01;
        wait_ready8();
        tick();
        in_valid8 = 1'b0;
        wait_valid8();
        check("b2b_last_sum", 16'(out_sum8), 16'h080);
        tick();
        b2b = 1'b0;
        check("w8_drain", 16'(exp8_q.size()), 16'd0);

        // WIDTH=1 driver
        run1(1'b1, 1'b1);
        check("w1_sum_11", 16'(out_sum1), 16'b10);
        run1(1'b1, 1'b0);
        check("w1_sum_10", 16'(out_sum1), 16'b01);
        run1(1'b0, 1'b0);
        check("w1_sum_00", 16'(out_sum1), 16'b00);
        check("w1_drain", 16'(exp1_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
